// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite write arbiter: FSM state codes, BRESP codes and default widths.
package axil_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;

  // Width of a requester index; never below one bit so single-requester builds stay legal.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant over NUM_REQ requests. With AXIL_WR_ARB_RR_EN defined the search starts at
// i_ptr and wraps; otherwise the lowest requesting index wins and no pointer input exists.
module rr_arbiter
  import axil_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef AXIL_WR_ARB_RR_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Visit candidates in priority order; the first requester reached takes the grant.
  always_comb begin
    int w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef AXIL_WR_ARB_RR_EN
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
`else
      w_cand = k;
`endif
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_any && (w_cand == j) && i_req[j]) begin
          o_grant[j] = 1'b1;
          o_idx      = IDX_W'(j);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axil_write_arbiter.sv
// Shares one AXI4-Lite write master port (AW/W/B) between NUM_REQ single-beat requesters.
// Define AXIL_WR_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module axil_write_arbiter
  import axil_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]       req_data,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]   req_strb,
  input  logic [NUM_REQ*3-1:0]            req_prot,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [1:0]                      resp_code,
  output logic                            AWVALID,
  input  logic                            AWREADY,
  output logic [ADDR_W-1:0]               AWADDR,
  output logic [2:0]                      AWPROT,
  output logic                            WVALID,
  input  logic                            WREADY,
  output logic [DATA_W-1:0]               WDATA,
  output logic [DATA_W/8-1:0]             WSTRB,
  input  logic                            BVALID,
  output logic                            BREADY,
  input  logic [1:0]                      BRESP
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idxWidth(NUM_REQ);

  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_grantIdx;
  logic                r_awDone;
  logic                r_wDone;
  logic [1:0]          r_bresp;
  logic [ADDR_W-1:0]   r_awAddr;
  logic [2:0]          r_awProt;
  logic [DATA_W-1:0]   r_wData;
  logic [STRB_W-1:0]   r_wStrb;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [2:0]          w_prot;

`ifdef AXIL_WR_ARB_RR_EN
  logic [IDX_W-1:0]    r_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );
`else
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );
`endif

  // Winner's payload, selected by the one-hot grant.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_strb = '0;
    w_prot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_addr = req_addr[j*ADDR_W +: ADDR_W];
        w_data = req_data[j*DATA_W +: DATA_W];
        w_strb = req_strb[j*STRB_W +: STRB_W];
        w_prot = req_prot[j*3 +: 3];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= IDLE;
      r_grantIdx <= '0;
      r_awDone   <= 1'b0;
      r_wDone    <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awAddr   <= '0;
      r_awProt   <= '0;
      r_wData    <= '0;
      r_wStrb    <= '0;
`ifdef AXIL_WR_ARB_RR_EN
      r_ptr      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grantIdx <= w_idx;
            r_awAddr   <= w_addr;
            r_awProt   <= w_prot;
            r_wData    <= w_data;
            r_wStrb    <= w_strb;
            r_awDone   <= 1'b0;
            r_wDone    <= 1'b0;
            r_state    <= ISSUE;
`ifdef AXIL_WR_ARB_RR_EN
            if (int'(w_idx) == NUM_REQ - 1) r_ptr <= '0;
            else                            r_ptr <= w_idx + IDX_W'(1);
`endif
          end
        end
        ISSUE: begin
          // AW and W complete independently, possibly in the same cycle.
          if (AWVALID && AWREADY) r_awDone <= 1'b1;
          if (WVALID && WREADY)   r_wDone  <= 1'b1;
          if ((r_awDone || AWREADY) && (r_wDone || WREADY)) r_state <= RESP;
        end
        RESP: begin
          if (BVALID) begin
            r_bresp <= BRESP;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign AWVALID   = (r_state == ISSUE) && !r_awDone;
  assign WVALID    = (r_state == ISSUE) && !r_wDone;
  assign BREADY    = (r_state == RESP);
  assign AWADDR    = r_awAddr;
  assign AWPROT    = r_awProt;
  assign WDATA     = r_wData;
  assign WSTRB     = r_wStrb;
  assign resp_code = (r_state == DONE) ? r_bresp : RESP_OKAY;

  always_comb begin
    resp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      resp_valid[j] = (r_state == DONE) && (r_grantIdx == IDX_W'(j));
    end
  end

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Directed testbench for axil_write_arbiter: single write, contention, split handshake,
// slave error and mid-transaction reset, with hand-computed expected values.
module tb_axil_write_arbiter;
  import axil_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_code;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;

  int checkCount = 0;
  int errorCount = 0;

  axil_write_arbiter dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_strb   (req_strb),
    .req_prot   (req_prot),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .AWADDR     (AWADDR),
    .AWPROT     (AWPROT),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .WDATA      (WDATA),
    .WSTRB      (WSTRB),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .BRESP      (BRESP)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic w, input logic bv, input logic [1:0] br);
    AWREADY = aw;
    WREADY  = w;
    BVALID  = bv;
    BRESP   = br;
  endtask

  task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
    req_addr[i*32 +: 32] = a;
    req_data[i*32 +: 32] = d;
    req_strb[i*4 +: 4]   = s;
    req_prot[i*3 +: 3]   = p;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic nextCycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic waitGrant(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
      nextCycle();
    end
  endtask

  logic [1:0] expGrant [4];
  logic       ok;
  logic       sawResp;

  initial begin
`ifdef AXIL_WR_ARB_RR_EN
    expGrant[0] = 2'b01; expGrant[1] = 2'b10; expGrant[2] = 2'b01; expGrant[3] = 2'b10;
`else
    expGrant[0] = 2'b01; expGrant[1] = 2'b01; expGrant[2] = 2'b01; expGrant[3] = 2'b01;
`endif
    ARESET    = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    req_prot  = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, RESP_OKAY);

    // Reset values
    nextCycle();
    nextCycle();
    ARESET = 1'b0;
    #1;
    checkOutput("rst_awvalid", AWVALID, 0);
    checkOutput("rst_wvalid", WVALID, 0);
    checkOutput("rst_bready", BREADY, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_code", resp_code, 0);
    checkOutput("rst_awaddr", AWADDR, 0);
    checkOutput("rst_wdata", WDATA, 0);
    checkOutput("rst_wstrb", WSTRB, 0);
    checkOutput("rst_awprot", AWPROT, 0);
    checkOutput("rst_req_ready", req_ready, 0);

    // Single write, slave always ready
    nextCycle();
    setReq(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0);
    setReq(1, 32'h0000_0020, 32'h1234_5678, 4'h3, 3'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, RESP_OKAY);
    req_valid = 2'b01;
    #1;
    checkOutput("single_c0_ready", req_ready, 2'b01);
    checkOutput("single_c0_awvalid", AWVALID, 0);
    nextCycle();
    req_valid = 2'b00;
    #1;
    checkOutput("single_c1_awvalid", AWVALID, 1);
    checkOutput("single_c1_wvalid", WVALID, 1);
    checkOutput("single_c1_awaddr", AWADDR, 32'h10);
    checkOutput("single_c1_wdata", WDATA, 32'hDEAD_BEEF);
    checkOutput("single_c1_wstrb", WSTRB, 4'hF);
    checkOutput("single_c1_bready", BREADY, 0);
    nextCycle();
    #1;
    checkOutput("single_c2_bready", BREADY, 1);
    checkOutput("single_c2_awvalid", AWVALID, 0);
    checkOutput("single_c2_resp_valid", resp_valid, 0);
    nextCycle();
    #1;
    checkOutput("single_c3_resp_valid", resp_valid, 2'b01);
    checkOutput("single_c3_resp_code", resp_code, RESP_OKAY);
    checkOutput("single_c3_bready", BREADY, 0);
    nextCycle();
    #1;
    checkOutput("single_c4_resp_valid", resp_valid, 0);

    // Contention from a fresh reset so the rotation starts at requester 0
    nextCycle();
    ARESET = 1'b1;
    nextCycle();
    ARESET = 1'b0;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      waitGrant(ok);
      checkOutput("cont_grant_seen", ok, 1);
      checkOutput("cont_grant", req_ready, expGrant[t]);
      nextCycle();
      #1;
      checkOutput("cont_awaddr", AWADDR, (expGrant[t] == 2'b01) ? 32'h10 : 32'h20);
      checkOutput("cont_awprot", AWPROT, (expGrant[t] == 2'b01) ? 3'd0 : 3'd5);
      checkOutput("cont_wstrb", WSTRB, (expGrant[t] == 2'b01) ? 4'hF : 4'h3);
      nextCycle();
      nextCycle();
      #1;
      checkOutput("cont_resp_valid", resp_valid, expGrant[t]);
      nextCycle();
    end
    req_valid = 2'b00;

    // Split handshake: W accepted in cycle 1, AW only in cycle 4
    applyStimulus(1'b0, 1'b0, 1'b0, RESP_OKAY);
    nextCycle();
    req_valid = 2'b10;
    #1;
    checkOutput("split_c0_ready", req_ready, 2'b10);
    nextCycle();
    req_valid = 2'b00;
    applyStimulus(1'b0, 1'b1, 1'b0, RESP_OKAY);
    #1;
    checkOutput("split_c1_wvalid", WVALID, 1);
    checkOutput("split_c1_awvalid", AWVALID, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, RESP_OKAY);
    #1;
    checkOutput("split_c2_wvalid", WVALID, 0);
    checkOutput("split_c2_awvalid", AWVALID, 1);
    checkOutput("split_c2_awaddr", AWADDR, 32'h20);
    nextCycle();
    #1;
    checkOutput("split_c3_awvalid", AWVALID, 1);
    checkOutput("split_c3_awaddr", AWADDR, 32'h20);
    checkOutput("split_c3_bready", BREADY, 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, RESP_OKAY);
    #1;
    checkOutput("split_c4_awvalid", AWVALID, 1);
    checkOutput("split_c4_bready", BREADY, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, RESP_OKAY);
    #1;
    checkOutput("split_c5_bready", BREADY, 1);
    checkOutput("split_c5_awvalid", AWVALID, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, RESP_OKAY);
    #1;
    checkOutput("split_c6_resp_valid", resp_valid, 2'b10);
    checkOutput("split_c6_resp_code", resp_code, RESP_OKAY);
    nextCycle();
    #1;
    checkOutput("split_c7_resp_valid", resp_valid, 0);

    // Slave error with BVALID delayed; requester 1 withdraws while waiting
    nextCycle();
    req_valid = 2'b11;
    applyStimulus(1'b1, 1'b1, 1'b0, RESP_OKAY);
    #1;
    checkOutput("err_c0_ready", req_ready, 2'b01);
    nextCycle();
    req_valid = 2'b10;
    #1;
    checkOutput("err_c1_awvalid", AWVALID, 1);
    checkOutput("err_c1_req_ready", req_ready, 0);
    for (int c = 2; c < 8; c++) begin
      nextCycle();
      #1;
      checkOutput("err_wait_bready", BREADY, 1);
      checkOutput("err_wait_resp_valid", resp_valid, 0);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, RESP_SLVERR);
    #1;
    checkOutput("err_c8_bready", BREADY, 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, RESP_OKAY);
    req_valid = 2'b00;
    #1;
    checkOutput("err_c9_resp_valid", resp_valid, 2'b01);
    checkOutput("err_c9_resp_code", resp_code, RESP_SLVERR);
    nextCycle();
    #1;
    checkOutput("err_c10_resp_valid", resp_valid, 0);
    checkOutput("err_c10_resp_code", resp_code, 0);
    checkOutput("err_c10_req_ready", req_ready, 0);

    // Reset while AWVALID is high
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, RESP_OKAY);
    req_valid = 2'b01;
    #1;
    checkOutput("rstmid_c0_ready", req_ready, 2'b01);
    nextCycle();
    req_valid = 2'b00;
    #1;
    checkOutput("rstmid_c1_awvalid", AWVALID, 1);
    ARESET = 1'b1;
    nextCycle();
    ARESET = 1'b0;
    #1;
    checkOutput("rstmid_awvalid", AWVALID, 0);
    checkOutput("rstmid_wvalid", WVALID, 0);
    checkOutput("rstmid_awaddr", AWADDR, 0);
    checkOutput("rstmid_wdata", WDATA, 0);
    checkOutput("rstmid_wstrb", WSTRB, 0);
    checkOutput("rstmid_bready", BREADY, 0);
    checkOutput("rstmid_resp_valid", resp_valid, 0);
    sawResp = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, RESP_OKAY);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      #1;
      sawResp = sawResp | (|resp_valid) | AWVALID | BREADY;
    end
    checkOutput("rstmid_quiet", sawResp, 0);
    nextCycle();
    req_valid = 2'b10;
    #1;
    checkOutput("fresh_c0_ready", req_ready, 2'b10);
    nextCycle();
    req_valid = 2'b00;
    #1;
    checkOutput("fresh_c1_awaddr", AWADDR, 32'h20);
    checkOutput("fresh_c1_wdata", WDATA, 32'h1234_5678);
    nextCycle();
    #1;
    checkOutput("fresh_c2_bready", BREADY, 1);
    nextCycle();
    #1;
    checkOutput("fresh_c3_resp_valid", resp_valid, 2'b10);
    checkOutput("fresh_c3_resp_code", resp_code, RESP_OKAY);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
